niosbase_pio_out: RTL and testbench



---
 rtl/niosbase_pio_out.sv | 85 ++++++++
 tb/tb_niosbase_pio_out.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/niosbase_pio_out.sv
// niosbase_pio_out: Avalon-MM output PIO with atomic set/clear and a one-shot masked pulse engine.
// The output is driven only from registers, so out_port never glitches on bus activity.
module niosbase_pio_out #(
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  done_q, done_d;
    logic                  irq_en_q, irq_en_d;
    logic [31:0]           readdata_q, readdata_d;
    logic                  wr, busy, unused_wd;

    assign wr        = chipselect & ~write_n;
    assign busy      = count_q != '0;
    assign unused_wd = ^writedata;

    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        count_d  = busy ? count_q - CNT_WIDTH'(1) : count_q;
        if (wr) begin
            case (address)
                3'd0: data_d = writedata[DATA_WIDTH-1:0];
                3'd1: mask_d = writedata[DATA_WIDTH-1:0];
                3'd2: count_d = writedata[CNT_WIDTH-1:0];
                3'd3: done_d = writedata[1] ? 1'b0 : done_q;
                3'd4: data_d = data_q | writedata[DATA_WIDTH-1:0];
                3'd5: data_d = data_q & ~writedata[DATA_WIDTH-1:0];
                3'd6: irq_en_d = writedata[0];
                default: ;
            endcase
        end
        // Expiry overrides a same-edge clear and is not cancelled by a same-edge reload.
        if (count_q == CNT_WIDTH'(1)) done_d = 1'b1;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            3'd0: readdata_d[DATA_WIDTH-1:0] = data_q;
            3'd1: readdata_d[DATA_WIDTH-1:0] = mask_q;
            3'd2: readdata_d[CNT_WIDTH-1:0] = count_q;
            3'd3: readdata_d[1:0] = {done_q, busy};
            3'd6: readdata_d[0] = irq_en_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            mask_q     <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            count_q    <= count_d;
            done_q     <= done_d;
            irq_en_q   <= irq_en_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = data_q ^ (mask_q & {DATA_WIDTH{busy}});
    assign irq      = done_q & irq_en_q;
endmodule

// File: tb/tb_niosbase_pio_out.sv
// tb_niosbase_pio_out: directed stimulus posts expectations tagged with a due cycle;
// an independent monitor checks them against readdata/out_port/irq when that cycle arrives.
module tb_niosbase_pio_out;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [15:0] out_port;
    logic        irq;

    niosbase_pio_out #(
        .DATA_WIDTH (16),
        .RESET_VALUE(16'h00A5),
        .CNT_WIDTH  (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] v;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] mon_act;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    task automatic push(int due, int kind, logic [31:0] v, string name);
        exp_t e;
        e = '{due, kind, v, name};
        sb.push_back(e);
    endtask

    task automatic po(int due, logic [15:0] v, string name);
        push(due, 1, 32'(v), name);
    endtask

    task automatic iq(int due, logic v, string name);
        push(due, 2, 32'(v), name);
    endtask

    task automatic idle();
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
    endtask

    task automatic wr(logic [2:0] a, logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
    endtask

    task automatic rd(logic [2:0] a, logic [31:0] exp, string name);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        push(cyc + 1, 0, exp, name);
    endtask

    // Monitor: samples 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                mon_act = sb[i].kind == 0 ? readdata : sb[i].kind == 1 ? 32'(out_port) : 32'(irq);
                chk(sb[i].name, mon_act, sb[i].v);
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int e;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_out", 32'(out_port), 32'h00A5);
        chk("rst_rd", readdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd(3'd0, 32'h000000A5, "rd_data_rst");
        rd(3'd3, 32'h0, "rd_status_rst");

        wr(3'd0, 32'h1234); po(cyc + 1, 16'h1234, "data_wr");
        wr(3'd4, 32'h00F0); po(cyc + 1, 16'h12F4, "outset");
        wr(3'd5, 32'h0204); po(cyc + 1, 16'h10F0, "outclear");
        rd(3'd4, 32'h0, "rd_outset");
        rd(3'd5, 32'h0, "rd_outclear");
        rd(3'd7, 32'h0, "rd_reserved");
        rd(3'd0, 32'h10F0, "rd_data");

        wr(3'd1, 32'h000F);
        wr(3'd0, 32'h0);
        rd(3'd1, 32'h0000000F, "rd_mask");
        wr(3'd6, 32'h1);
        wr(3'd2, 32'd5);
        e = cyc + 1;
        for (int k = 0; k < 5; k++) po(e + k, 16'h000F, "pulse5_on");
        po(e + 5, 16'h0000, "pulse5_off");
        iq(e + 4, 1'b0, "irq_pre");
        iq(e + 5, 1'b1, "irq_done");
        rd(3'd3, 32'h1, "st_busy");
        repeat (4) idle();
        rd(3'd3, 32'h2, "st_done");
        wr(3'd3, 32'h2); iq(cyc + 1, 1'b0, "irq_clr");
        rd(3'd3, 32'h0, "st_clr");

        wr(3'd2, 32'd10);
        e = cyc + 1;
        po(e, 16'h000F, "p10_on");
        po(e + 3, 16'h000F, "p10_pre_reload");
        po(e + 6, 16'h000F, "restart_last");
        po(e + 7, 16'h0000, "restart_off");
        repeat (3) idle();
        wr(3'd2, 32'd3);
        rd(3'd3, 32'h1, "st_restart_busy");
        repeat (2) idle();
        rd(3'd3, 32'h2, "st_restart_done");
        wr(3'd3, 32'h2);

        wr(3'd2, 32'd10);
        e = cyc + 1;
        po(e + 3, 16'h000F, "abort_pre");
        po(e + 4, 16'h0000, "abort_off");
        iq(e + 5, 1'b0, "abort_irq");
        repeat (3) idle();
        wr(3'd2, 32'd0);
        rd(3'd3, 32'h0, "st_abort");

        wr(3'd2, 32'd2);
        e = cyc + 1;
        iq(e + 2, 1'b1, "irq_set_wins");
        idle();
        wr(3'd3, 32'h2);
        rd(3'd3, 32'h2, "st_set_wins");
        wr(3'd3, 32'h2);

        wr(3'd2, 32'd2);
        e = cyc + 1;
        po(e + 2, 16'h000F, "reload_on");
        iq(e + 2, 1'b1, "irq_reload");
        po(e + 5, 16'h000F, "reload_last");
        po(e + 6, 16'h0000, "reload_off");
        idle();
        wr(3'd2, 32'd4);
        rd(3'd3, 32'h3, "st_reload");
        repeat (3) idle();
        rd(3'd3, 32'h2, "st_reload_done");

        wr(3'd0, 32'h0300);
        wr(3'd2, 32'd20);
        e = cyc + 1;
        po(e, 16'h030F, "pre_rst_pulse");
        repeat (2) idle();
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("rst_mid_out", 32'(out_port), 32'h00A5);
        chk("rst_mid_rd", readdata, 32'h0);
        chk("rst_mid_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(3'd3, 32'h0, "st_after_rst");
        rd(3'd0, 32'h000000A5, "data_after_rst");
        rd(3'd6, 32'h0, "irqen_after_rst");
        rd(3'd1, 32'h0, "mask_after_rst");
        repeat (3) idle();
        foreach (sb[i]) begin
            n_chk++;
            $display("FAIL %s: got unchecked expected checked at cycle %0d", sb[i].name, sb[i].due);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
